// File: rtl/alu_exec_stage.sv
// Execute stage of the 16-bit core: two-level operand forwarding, single-cycle
// ALU, 16-step serial multiplier and the {Z,N,C} condition-code register.
//
// state | meaning
// IDLE  | single-cycle ops execute; a MUL captures its operands and stalls
// BUSY  | one shift-add multiply step per cycle, cnt selects the multiplier bit
// DONE  | product presented downstream, flags written, stall released
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_WB,
  input  logic        i_Mem,
  input  logic        i_chg_flag,
  input  logic [3:0]  i_alu_op,
  input  logic        i_use_immd,
  input  logic [31:0] i_pc,
  input  logic [2:0]  i_Rsrc1,
  input  logic [2:0]  i_Rsrc2,
  input  logic [2:0]  i_Rdst,
  input  logic [15:0] i_immd,
  input  logic [15:0] i_read_data1,
  input  logic [15:0] i_read_data2,
  input  logic        i_fwd_mem_wb,
  input  logic [2:0]  i_fwd_mem_rd,
  input  logic [15:0] i_fwd_mem_data,
  input  logic        i_fwd_wb_wb,
  input  logic [2:0]  i_fwd_wb_rd,
  input  logic [15:0] i_fwd_wb_data,
  output logic [15:0] o_result,
  output logic        o_WB,
  output logic        o_Mem,
  output logic [2:0]  o_Rdst,
  output logic [15:0] o_store_data,
  output logic [31:0] o_pc,
  output logic [2:0]  o_flags,
  output logic        o_stall
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_INC  = 4'd6;
  localparam logic [3:0] OP_DEC  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_MOV  = 4'd10;
  localparam logic [3:0] OP_LDM  = 4'd11;
  localparam logic [3:0] OP_SETC = 4'd12;
  localparam logic [3:0] OP_CLRC = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] acc;
  logic [31:0] partial;
  logic [2:0]  flags;
  logic [2:0]  flags_nxt;

  logic [15:0] src1_val;
  logic [15:0] src2_val;
  logic [15:0] opnd_a;
  logic [15:0] opnd_b;
  logic [3:0]  shamt;

  logic [15:0] alu_res;
  logic        wr_zn;
  logic        wr_c;
  logic        c_val;
  logic [16:0] sum17;
  logic [16:0] sh17;

  logic        mul_issue;

  // Resolve both sources: ALU/mem buffer wins over mem/WB buffer over reg file.
  always_comb begin
    if (i_fwd_mem_wb && (i_fwd_mem_rd == i_Rsrc1))
      src1_val = i_fwd_mem_data;
    else if (i_fwd_wb_wb && (i_fwd_wb_rd == i_Rsrc1))
      src1_val = i_fwd_wb_data;
    else
      src1_val = i_read_data1;

    if (i_fwd_mem_wb && (i_fwd_mem_rd == i_Rsrc2))
      src2_val = i_fwd_mem_data;
    else if (i_fwd_wb_wb && (i_fwd_wb_rd == i_Rsrc2))
      src2_val = i_fwd_wb_data;
    else
      src2_val = i_read_data2;
  end

  assign opnd_a       = src1_val;
  assign opnd_b       = i_use_immd ? i_immd : src2_val;
  assign shamt        = i_immd[3:0];
  assign o_store_data = src2_val;
  assign o_pc         = i_pc;
  assign o_Rdst       = i_Rdst;
  assign o_flags      = flags;
  assign mul_issue    = (state == S_IDLE) && (i_alu_op == OP_MUL);

  // Single-cycle ALU: result plus which flag fields the op is allowed to write.
  always_comb begin
    alu_res = 16'd0;
    wr_zn   = 1'b0;
    wr_c    = 1'b0;
    c_val   = 1'b0;
    sum17   = 17'd0;
    sh17    = 17'd0;
    case (i_alu_op)
      OP_ADD: begin
        sum17   = {1'b0, opnd_a} + {1'b0, opnd_b};
        alu_res = sum17[15:0];
        c_val   = sum17[16];
        wr_zn   = 1'b1;
        wr_c    = 1'b1;
      end
      OP_SUB: begin
        // bit 16 of a 17-bit difference is the unsigned borrow
        sum17   = {1'b0, opnd_a} - {1'b0, opnd_b};
        alu_res = sum17[15:0];
        c_val   = sum17[16];
        wr_zn   = 1'b1;
        wr_c    = 1'b1;
      end
      OP_AND: begin
        alu_res = opnd_a & opnd_b;
        wr_zn   = 1'b1;
      end
      OP_OR: begin
        alu_res = opnd_a | opnd_b;
        wr_zn   = 1'b1;
      end
      OP_NOT: begin
        alu_res = ~opnd_a;
        wr_zn   = 1'b1;
      end
      OP_INC: begin
        sum17   = {1'b0, opnd_a} + 17'd1;
        alu_res = sum17[15:0];
        c_val   = sum17[16];
        wr_zn   = 1'b1;
        wr_c    = 1'b1;
      end
      OP_DEC: begin
        sum17   = {1'b0, opnd_a} - 17'd1;
        alu_res = sum17[15:0];
        c_val   = sum17[16];
        wr_zn   = 1'b1;
        wr_c    = 1'b1;
      end
      OP_SHL: begin
        // extra top bit catches the last bit shifted out
        sh17    = {1'b0, opnd_a} << shamt;
        alu_res = sh17[15:0];
        c_val   = sh17[16];
        wr_zn   = 1'b1;
        wr_c    = (shamt != 4'd0);
      end
      OP_SHR: begin
        // extra bottom bit catches the last bit shifted out
        sh17    = {opnd_a, 1'b0} >> shamt;
        alu_res = sh17[16:1];
        c_val   = sh17[0];
        wr_zn   = 1'b1;
        wr_c    = (shamt != 4'd0);
      end
      OP_MOV:  alu_res = opnd_a;
      OP_LDM:  alu_res = i_immd;
      default: alu_res = 16'd0;
    endcase
  end

  // Multiply partial product for the multiplier bit selected by cnt.
  assign partial = mul_b[cnt] ? ({16'd0, mul_a} << cnt) : 32'd0;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next state and pipeline outputs; stall cycles emit a bubble downstream.
  always_comb begin
    state_nxt = state;
    o_result  = 16'd0;
    o_WB      = 1'b0;
    o_Mem     = 1'b0;
    o_stall   = 1'b0;
    if (rst) begin
      case (state)
        S_IDLE: begin
          if (i_alu_op == OP_MUL) begin
            state_nxt = S_BUSY;
            o_stall   = 1'b1;
          end else begin
            o_result = alu_res;
            o_WB     = i_WB;
            o_Mem    = i_Mem;
          end
        end
        S_BUSY: begin
          o_stall = 1'b1;
          if (cnt == 4'd15)
            state_nxt = S_DONE;
        end
        S_DONE: begin
          state_nxt = S_IDLE;
          o_result  = acc[15:0];
          o_WB      = i_WB;
          o_Mem     = i_Mem;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Multiplier datapath: operands frozen at issue so forwarding changes during the stall are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 4'd0;
      acc   <= 32'd0;
      mul_a <= 16'd0;
      mul_b <= 16'd0;
    end else if (mul_issue) begin
      cnt   <= 4'd0;
      acc   <= 32'd0;
      mul_a <= opnd_a;
      mul_b <= opnd_b;
    end else if (state == S_BUSY) begin
      cnt <= cnt + 4'd1;
      acc <= acc + partial;
    end
  end

  // Flag update: only when an op completes; SETC/CLRC ignore i_chg_flag.
  always_comb begin
    flags_nxt = flags;
    if ((state == S_IDLE) && (i_alu_op != OP_MUL)) begin
      if (i_chg_flag && wr_zn)
        flags_nxt[2:1] = {(alu_res == 16'd0), alu_res[15]};
      if (i_chg_flag && wr_c)
        flags_nxt[0] = c_val;
      if (i_alu_op == OP_SETC)
        flags_nxt[0] = 1'b1;
      if (i_alu_op == OP_CLRC)
        flags_nxt[0] = 1'b0;
    end else if ((state == S_DONE) && i_chg_flag) begin
      flags_nxt = {(acc[15:0] == 16'd0), acc[15], (acc[31:16] != 16'd0)};
    end
  end

  // Condition-code register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flags <= 3'b000;
    else
      flags <= flags_nxt;
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed cases pinned to hand-computed values,
// then randomized instructions checked against a behavioural model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_WB = 1'b0, i_Mem = 1'b0, i_chg_flag = 1'b0;
  logic [3:0]  i_alu_op = 4'd0;
  logic        i_use_immd = 1'b0;
  logic [31:0] i_pc = 32'd0;
  logic [2:0]  i_Rsrc1 = 3'd0, i_Rsrc2 = 3'd0, i_Rdst = 3'd0;
  logic [15:0] i_immd = 16'd0, i_read_data1 = 16'd0, i_read_data2 = 16'd0;
  logic        i_fwd_mem_wb = 1'b0;
  logic [2:0]  i_fwd_mem_rd = 3'd0;
  logic [15:0] i_fwd_mem_data = 16'd0;
  logic        i_fwd_wb_wb = 1'b0;
  logic [2:0]  i_fwd_wb_rd = 3'd0;
  logic [15:0] i_fwd_wb_data = 16'd0;
  logic [15:0] o_result;
  logic        o_WB, o_Mem;
  logic [2:0]  o_Rdst;
  logic [15:0] o_store_data;
  logic [31:0] o_pc;
  logic [2:0]  o_flags;
  logic        o_stall;

  alu_exec_stage dut (
    .clk(clk), .rst(rst),
    .i_WB(i_WB), .i_Mem(i_Mem), .i_chg_flag(i_chg_flag),
    .i_alu_op(i_alu_op), .i_use_immd(i_use_immd), .i_pc(i_pc),
    .i_Rsrc1(i_Rsrc1), .i_Rsrc2(i_Rsrc2), .i_Rdst(i_Rdst),
    .i_immd(i_immd), .i_read_data1(i_read_data1), .i_read_data2(i_read_data2),
    .i_fwd_mem_wb(i_fwd_mem_wb), .i_fwd_mem_rd(i_fwd_mem_rd), .i_fwd_mem_data(i_fwd_mem_data),
    .i_fwd_wb_wb(i_fwd_wb_wb), .i_fwd_wb_rd(i_fwd_wb_rd), .i_fwd_wb_data(i_fwd_wb_data),
    .o_result(o_result), .o_WB(o_WB), .o_Mem(o_Mem), .o_Rdst(o_Rdst),
    .o_store_data(o_store_data), .o_pc(o_pc), .o_flags(o_flags), .o_stall(o_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // model state and per-cycle expectations
  logic [2:0]  m_flags = 3'b000;
  logic        chk_en = 1'b0;
  logic        exp_data = 1'b0;
  logic        exp_stall = 1'b0, exp_wb = 1'b0, exp_mem = 1'b0;
  logic [15:0] exp_result = 16'd0, exp_store = 16'd0;
  logic [2:0]  exp_rdst = 3'd0;
  logic [31:0] exp_pc = 32'd0;
  logic [15:0] obs_result = 16'd0;
  logic        obs_wb = 1'b0;
  int          obs_stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] resolve(input logic [2:0] idx, input logic [15:0] rf);
    if (i_fwd_mem_wb && i_fwd_mem_rd == idx) return i_fwd_mem_data;
    if (i_fwd_wb_wb && i_fwd_wb_rd == idx) return i_fwd_wb_data;
    return rf;
  endfunction

  // Architectural meaning of each single-cycle opcode, in plain integer arithmetic.
  function automatic void alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] imm, input logic chg, input logic [2:0] f,
                                    output logic [15:0] res, output logic [2:0] nf);
    int unsigned ua, ub, r, s;
    logic cv, wzn, wc;
    ua = 32'(a); ub = 32'(b); s = 32'(imm[3:0]);
    r = 0; cv = 1'b0; wzn = 1'b0; wc = 1'b0;
    case (op)
      4'd1:  begin r = ua + ub; cv = (r > 65535); wzn = 1; wc = 1; end
      4'd2:  begin r = ua - ub; cv = (ua < ub); wzn = 1; wc = 1; end
      4'd3:  begin r = ua & ub; wzn = 1; end
      4'd4:  begin r = ua | ub; wzn = 1; end
      4'd5:  begin r = ~ua; wzn = 1; end
      4'd6:  begin r = ua + 1; cv = (ua == 65535); wzn = 1; wc = 1; end
      4'd7:  begin r = ua - 1; cv = (ua == 0); wzn = 1; wc = 1; end
      4'd8:  begin
               wzn = 1;
               if (s == 0) r = ua;
               else begin r = ua << s; cv = ((ua >> (16 - s)) & 32'd1) != 0; wc = 1; end
             end
      4'd9:  begin
               wzn = 1;
               if (s == 0) r = ua;
               else begin r = ua >> s; cv = ((ua >> (s - 1)) & 32'd1) != 0; wc = 1; end
             end
      4'd10: r = ua;
      4'd11: r = 32'(imm);
      default: r = 0;
    endcase
    res = 16'(r);
    nf = f;
    if (chg && wzn) begin nf[2] = (res == 16'd0); nf[1] = res[15]; end
    if (chg && wc) nf[0] = cv;
    if (op == 4'd12) nf[0] = 1'b1;
    if (op == 4'd13) nf[0] = 1'b0;
  endfunction

  // Single compare process: every cycle with checking enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(o_stall), 32'(exp_stall));
      check("wb",    32'(o_WB),    32'(exp_wb));
      check("mem",   32'(o_Mem),   32'(exp_mem));
      check("pc",    o_pc,         exp_pc);
      check("flags", 32'(o_flags), 32'(m_flags));
      if (exp_data) begin
        check("result", 32'(o_result),     32'(exp_result));
        check("rdst",   32'(o_Rdst),       32'(exp_rdst));
        check("store",  32'(o_store_data), 32'(exp_store));
      end
    end
  end

  // Runs the instruction currently on the inputs to completion (including a full MUL).
  task automatic issue();
    logic [15:0] a, b, res;
    logic [2:0]  nf;
    logic [31:0] prod;
    a = resolve(i_Rsrc1, i_read_data1);
    b = i_use_immd ? i_immd : resolve(i_Rsrc2, i_read_data2);
    exp_pc = i_pc;
    if (i_alu_op == 4'd14) begin
      prod = 32'(a) * 32'(b);
      obs_stall_cnt = 0;
      for (int k = 0; k < 17; k++) begin
        exp_stall = 1'b1; exp_wb = 1'b0; exp_mem = 1'b0; exp_data = 1'b0;
        @(negedge clk);
        if (o_stall === 1'b1 && o_WB === 1'b0) obs_stall_cnt++;
        @(posedge clk); #1;
        // downstream slots keep moving while the front end is held
        i_fwd_mem_data = 16'($urandom);
        i_fwd_wb_data  = 16'($urandom);
      end
      check("mul_stall_len", 32'(obs_stall_cnt), 32'd17);
      res = prod[15:0];
      nf = m_flags;
      if (i_chg_flag) nf = {(res == 16'd0), res[15], (prod[31:16] != 16'd0)};
    end else begin
      alu_model(i_alu_op, a, b, i_immd, i_chg_flag, m_flags, res, nf);
    end
    exp_stall = 1'b0; exp_result = res; exp_wb = i_WB; exp_mem = i_Mem;
    exp_rdst = i_Rdst; exp_store = resolve(i_Rsrc2, i_read_data2); exp_data = 1'b1;
    @(negedge clk);
    obs_result = o_result; obs_wb = o_WB;
    @(posedge clk); #1;
    m_flags = nf;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic chg, input logic [2:0] rs1,
                           input logic [15:0] rd1, input logic use_imm, input logic [15:0] imm);
    i_alu_op = op; i_chg_flag = chg; i_Rsrc1 = rs1; i_read_data1 = rd1;
    i_use_immd = use_imm; i_immd = imm; i_WB = 1'b1; i_Mem = 1'b0;
    i_Rsrc2 = 3'd6; i_read_data2 = 16'h0000; i_Rdst = 3'd2; i_pc = i_pc + 32'd2;
    i_fwd_mem_wb = 1'b0; i_fwd_wb_wb = 1'b0;
  endtask

  initial begin
    // power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("reset_flags", 32'(o_flags), 32'd0);
    chk_en = 1'b1;

    // ADD 0xFFFF + 1 -> 0, Z=1 N=0 C=1
    set_instr(4'd1, 1'b1, 3'd1, 16'hFFFF, 1'b1, 16'h0001);
    issue();
    check("pin_add_result", 32'(obs_result), 32'h0000);
    check("pin_add_flags", 32'(o_flags), 32'b101);

    // forwarding priority on MOV
    set_instr(4'd10, 1'b0, 3'd3, 16'h3333, 1'b0, 16'h0000);
    i_fwd_mem_wb = 1'b1; i_fwd_mem_rd = 3'd3; i_fwd_mem_data = 16'h1111;
    i_fwd_wb_wb  = 1'b1; i_fwd_wb_rd  = 3'd3; i_fwd_wb_data  = 16'h2222;
    issue();
    check("pin_fwd_mem", 32'(obs_result), 32'h1111);
    i_fwd_mem_wb = 1'b0; i_pc = i_pc + 32'd2;
    issue();
    check("pin_fwd_wb", 32'(obs_result), 32'h2222);

    // MUL 0x0100 * 0x0100, operand A forwarded; forwarding data scrambled during stall
    set_instr(4'd14, 1'b1, 3'd1, 16'hDEAD, 1'b1, 16'h0100);
    i_fwd_mem_wb = 1'b1; i_fwd_mem_rd = 3'd1; i_fwd_mem_data = 16'h0100;
    issue();
    check("pin_mul_result", 32'(obs_result), 32'h0000);
    check("pin_mul_wb", 32'(obs_wb), 32'd1);
    check("pin_mul_flags", 32'(o_flags), 32'b101);

    // shifts
    set_instr(4'd8, 1'b1, 3'd0, 16'h8001, 1'b1, 16'h0001);
    issue();
    check("pin_shl_result", 32'(obs_result), 32'h0002);
    check("pin_shl_flags", 32'(o_flags), 32'b001);
    set_instr(4'd9, 1'b1, 3'd0, 16'h8001, 1'b1, 16'h0000);
    issue();
    check("pin_shr0_result", 32'(obs_result), 32'h8001);
    check("pin_shr0_flags", 32'(o_flags), 32'b011);

    // CLRC, SETC and AND with i_chg_flag=0
    set_instr(4'd13, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    issue();
    check("pin_clrc_flags", 32'(o_flags), 32'b010);
    set_instr(4'd12, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    issue();
    check("pin_setc_flags", 32'(o_flags), 32'b011);
    set_instr(4'd3, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
    issue();
    check("pin_and_nochg_flags", 32'(o_flags), 32'b011);

    // reset in the middle of a multiply (counter = 7)
    set_instr(4'd14, 1'b1, 3'd1, 16'h1234, 1'b1, 16'h0005);
    chk_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("busy_before_rst", 32'(o_stall), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_flags", 32'(o_flags), 32'd0);
    check("rst_wb_mem", 32'({o_WB, o_Mem}), 32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    i_alu_op = 4'd0; i_chg_flag = 1'b0;
    @(negedge clk); rst = 1'b1;
    m_flags = 3'b000;
    @(posedge clk); #1;
    chk_en = 1'b1;
    set_instr(4'd1, 1'b1, 3'd4, 16'h8000, 1'b1, 16'h8000);
    issue();
    check("pin_post_rst_add", 32'(obs_result), 32'h0000);
    check("pin_post_rst_flags", 32'(o_flags), 32'b101);

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      i_alu_op     = 4'($urandom_range(0, 15));
      i_WB         = 1'($urandom_range(0, 1));
      i_Mem        = 1'($urandom_range(0, 1));
      i_chg_flag   = 1'($urandom_range(0, 1));
      i_use_immd   = 1'($urandom_range(0, 1));
      i_pc         = $urandom;
      i_Rsrc1      = 3'($urandom_range(0, 7));
      i_Rsrc2      = 3'($urandom_range(0, 7));
      i_Rdst       = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: i_immd = 16'($urandom_range(0, 16));
        1: i_immd = 16'hFFFF;
        default: i_immd = 16'($urandom);
      endcase
      i_read_data1 = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      i_read_data2 = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      i_fwd_mem_wb   = 1'($urandom_range(0, 1));
      i_fwd_mem_rd   = ($urandom_range(0, 2) == 0) ? i_Rsrc1 : 3'($urandom_range(0, 7));
      i_fwd_mem_data = 16'($urandom);
      i_fwd_wb_wb    = 1'($urandom_range(0, 1));
      i_fwd_wb_rd    = ($urandom_range(0, 2) == 0) ? i_Rsrc2 : 3'($urandom_range(0, 7));
      i_fwd_wb_data  = 16'($urandom);
      issue();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute stage of the 16-bit core. It consumes the operands and control fields held in the decode/ALU pipeline buffer and resolves both source operands through a two-level forwarding network. It performs single-cycle ALU operations plus a 16-cycle serial multiply, owns the condition-code register (Z, N, C), and drives the result and control fields into the ALU/memory buffer. During a multiply it stalls the front of the pipeline.

## Interface
- No parameters; data width 16, register index width 3, PC width 32 are fixed.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- i_WB, i_Mem, i_chg_flag  in  1 each  control fields from decode/ALU buffer
- i_alu_op  in  4  operation code (encoding below)
- i_use_immd  in  1  operand B = i_immd instead of register
- i_pc  in  32  instruction PC, passed through
- i_Rsrc1, i_Rsrc2, i_Rdst  in  3 each  register indices
- i_immd, i_read_data1, i_read_data2  in  16 each  immediate and register-file read data
- i_fwd_mem_wb, i_fwd_mem_rd, i_fwd_mem_data  in  1/3/16  writeback from the ALU/memory buffer (priority 1)
- i_fwd_wb_wb, i_fwd_wb_rd, i_fwd_wb_data  in  1/3/16  writeback from the memory/WB buffer (priority 2)
- o_result  out  16  ALU result
- o_WB, o_Mem  out  1 each  control fields forwarded; forced 0 on bubble
- o_Rdst  out  3  destination index
- o_store_data  out  16  forwarded operand B register value, for stores
- o_pc  out  32  pass-through of i_pc
- o_flags  out  3  {Z,N,C} condition-code register
- o_stall  out  1  high: upstream buffers and fetch hold (decode/ALU buffer enable = ~o_stall)

## Operation
- Operand resolution for each source:
  - If i_fwd_mem_wb and i_fwd_mem_rd equals the index, use i_fwd_mem_data.
  - Else if i_fwd_wb_wb and i_fwd_wb_rd equals the index, use i_fwd_wb_data.
  - Else use the register-file data.
  - A = resolved Rsrc1. B = i_immd if i_use_immd, else resolved Rsrc2. o_store_data = resolved Rsrc2 always.
- Opcodes and flag effects. "Logic ZN" means Z/N from the result, C unchanged.
  - 0 NOP: result 0, no flag change.
  - 1 ADD: A+B; C = carry out.
  - 2 SUB: A−B; C = borrow (A<B unsigned).
  - 3 AND, 4 OR: logic ZN.
  - 5 NOT: ~A, logic ZN.
  - 6 INC: A+1; C = carry out.
  - 7 DEC: A−1; C = borrow (A==0).
  - 8 SHL: A<<i_immd[3:0]; C = last bit shifted out.
  - 9 SHR: logical A>>i_immd[3:0]; C = last bit shifted out.
  - For SHL/SHR with shift amount 0: result A, C unchanged.
  - 10 MOV: result A. 11 LDM: result i_immd. Neither changes flags.
  - 12 SETC: C=1. 13 CLRC: C=0. Both regardless of i_chg_flag.
  - 14 MUL: low 16 bits of unsigned A×B; C = (high 16 bits ≠ 0).
  - 15: treated as NOP.
- Flags update at the clock edge only when i_chg_flag=1 and the operation completes that cycle. Z = (result==0). N = result[15]. SETC/CLRC write C only.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when i_alu_op=14. On entry, capture A and B into internal registers, clear the 32-bit accumulator, set counter=0.
  - BUSY: one shift-add step per cycle. Counter 0..15. At counter=15 → DONE.
  - DONE: present product; → IDLE unconditionally.
- o_stall = (IDLE and op=14) or BUSY.
- While o_stall=1: o_WB=0, o_Mem=0, and flags are not written (bubble to downstream).
- Captured multiply operands are immune to forwarding-source changes during the stall.

## Timing
- Single-cycle ops: o_result, o_WB, o_Mem, and o_Rdst are combinational from inputs in the same cycle. Flags are visible the cycle after.
- MUL issued in cycle T:
  - o_stall=1 in cycles T..T+16.
  - Valid o_result, o_WB=i_WB in T+17.
  - Flags updated at the end of T+17; the next instruction is accepted in T+18.
- Reset (rst=0, any time, including mid-multiply):
  - State → IDLE, counter → 0, accumulator → 0, o_flags → 3'b000.
  - While rst=0: o_stall=0, o_WB=0, o_Mem=0, o_result=0.
- Back-to-back MULs: the second MUL is seen in IDLE in T+18 and restarts the sequence; there is no idle gap beyond T+17.

## Test plan
- Reset: drive rst=0 mid-BUSY (counter=7) → o_stall drops immediately, o_flags=000; after release, an ADD executes normally.
- ADD 0xFFFF+0x0001, i_chg_flag=1 → o_result=0x0000; next cycle o_flags Z=1, N=0, C=1.
- Forwarding priority: Rsrc1=3; mem slot (rd=3, data 0x1111) and WB slot (rd=3, data 0x2222) both valid; op MOV → o_result=0x1111. With the mem slot invalid → 0x2222.
- MUL 0x0100×0x0100 issued at T → o_stall high T..T+16 with o_WB=0; at T+17 o_result=0x0000 and o_WB=1; flags Z=1, C=1. Changing forwarding data during the stall has no effect.
- SHL A=0x8001 by 1 → result 0x0002, C=1. SHR by 0 with C previously 1 → result A, C stays 1.
- SETC with i_chg_flag=0 → C=1. Subsequent AND with i_chg_flag=0 → flags unchanged.
